// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side UART controller.
// Oversamples RX_IN, takes a 2-of-3 majority vote in the middle of every bit
// and walks the frame: start, 8 data bits LSB first, optional parity, stop.
// Feeds the deserializer (deser_en / sampled_bit / bit_counter) and raises
// the frame flags data_valid, par_err and stp_err.
// Optional build macro RX_SYNC_EN: when defined, RX_IN goes through a
// 2-flop synchronizer first; every RX event then lands 2 cycles later.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  sampled_bit,
  output logic                  deser_en,
  output logic [3:0]            bit_counter,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                  state_q;
  logic [PRESCALE_W-1:0]   edgeCnt_q;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    parEn_q;
  logic                    parTyp_q;
  logic                    parAcc_q;
  logic [2:0]              samp_q;
  logic                    sampledBit_q;
  logic                    deserEn_q;
  logic [3:0]              bitCnt_q;
  logic                    dataValid_q;
  logic                    parErr_q;
  logic                    stpErr_q;

  logic                    rxBit;
  logic [PRESCALE_W-1:0]   prescSel_d;
  logic [PRESCALE_W-1:0]   halfCnt;
  logic [PRESCALE_W-1:0]   lastEdge;
  logic [PRESCALE_W-1:0]   strobeEdge;
  logic                    atLast;
  logic                    vote;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; resets to the idle-high level so reset never looks like a start bit
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RX_IN};
  end

  assign rxBit = sync_q[1];
`else
  assign rxBit = RX_IN;
`endif

  // Only 8, 16 and 32 are meaningful oversampling ratios; everything else falls back to 8
  always_comb begin
    prescSel_d = PRESCALE_W'(8);
    if (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32))
      prescSel_d = Prescale;
  end

  assign halfCnt    = presc_q >> 1;
  assign lastEdge   = presc_q - PRESCALE_W'(1);
  // The strobe is launched one edge early so it is visible while the counter
  // reads P-1, i.e. while bit_counter still names the bit being written
  assign strobeEdge = presc_q - PRESCALE_W'(2);
  assign atLast     = (edgeCnt_q == lastEdge);
  assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  // Frame sequencer: edge counter, three-point sampler, vote and all registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      edgeCnt_q    <= '0;
      presc_q      <= '0;
      parEn_q      <= 1'b0;
      parTyp_q     <= 1'b0;
      parAcc_q     <= 1'b0;
      samp_q       <= '0;
      sampledBit_q <= 1'b0;
      deserEn_q    <= 1'b0;
      bitCnt_q     <= '0;
      dataValid_q  <= 1'b0;
      parErr_q     <= 1'b0;
      stpErr_q     <= 1'b0;
    end else begin
      deserEn_q   <= 1'b0;
      dataValid_q <= 1'b0;

      if (state_q != IDLE) begin
        edgeCnt_q <= atLast ? '0 : edgeCnt_q + PRESCALE_W'(1);
        if (edgeCnt_q == halfCnt - PRESCALE_W'(1)) samp_q[0] <= rxBit;
        if (edgeCnt_q == halfCnt)                  samp_q[1] <= rxBit;
        if (edgeCnt_q == halfCnt + PRESCALE_W'(1)) samp_q[2] <= rxBit;
        if (edgeCnt_q == halfCnt + PRESCALE_W'(2)) sampledBit_q <= vote;
      end

      case (state_q)
        IDLE: begin
          if (!rxBit) begin
            state_q   <= START;
            edgeCnt_q <= '0;
            presc_q   <= prescSel_d;
            parEn_q   <= PAR_EN;
            parTyp_q  <= PAR_TYP;
            parAcc_q  <= 1'b0;
            parErr_q  <= 1'b0;
            stpErr_q  <= 1'b0;
          end
        end
        START: begin
          if (atLast) begin
            if (sampledBit_q) begin
              state_q <= IDLE;
            end else begin
              state_q  <= DATA;
              bitCnt_q <= 4'd1;
            end
          end
        end
        DATA: begin
          if (edgeCnt_q == strobeEdge) deserEn_q <= 1'b1;
          if (atLast) begin
            parAcc_q <= parAcc_q ^ sampledBit_q;
            if (bitCnt_q == 4'd8) begin
              bitCnt_q <= 4'd0;
              state_q  <= parEn_q ? PARITY : STOP;
            end else begin
              bitCnt_q <= bitCnt_q + 4'd1;
            end
          end
        end
        PARITY: begin
          if (atLast) begin
            if (sampledBit_q != (parAcc_q ^ parTyp_q)) parErr_q <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (atLast) begin
            if (!sampledBit_q) stpErr_q <= 1'b1;
            dataValid_q <= !parErr_q && sampledBit_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sampled_bit = sampledBit_q;
  assign deser_en    = deserEn_q;
  assign bit_counter = bitCnt_q;
  assign data_valid  = dataValid_q;
  assign par_err     = parErr_q;
  assign stp_err     = stpErr_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller of the UART RX path: oversamples the serial line, majority-votes each bit and sequences the frame (start, 8 data, optional parity, stop).
- Sits directly upstream of the RX deserializer. Drives its deser_en, sampled_bit and bit_counter (1..8) inputs; the deserializer writes sampled_bit into P_DATA[bit_counter-1].
- Also produces the frame-level data_valid, par_err and stp_err flags consumed by the RX top and the system controller.

Parameters:
- PRESCALE_W, 6, width of the Prescale input and the internal edge counter.

Ports:
- CLK  in  1  RX oversampling clock.
- RST  in  1  synchronous, active-high reset.
- RX_IN  in  1  serial line, idle high.
- Prescale  in  PRESCALE_W  oversampling ratio. Legal values are 8, 16 and 32; any other value is treated as 8.
- PAR_EN  in  1  1 = a parity bit follows the data.
- PAR_TYP  in  1  0 = even, 1 = odd.
- sampled_bit  out  1  majority-voted value of the current bit.
- deser_en  out  1  one-cycle write strobe to the deserializer.
- bit_counter  out  4  data bit index + 1 (1..8) during DATA; 0 otherwise.
- data_valid  out  1  one-cycle pulse marking a good frame.
- par_err  out  1  parity mismatch on the current/last frame.
- stp_err  out  1  stop bit sampled low.

Behaviour:
- Reset (synchronous, active-high, on a CLK edge with RST=1):
  - state=IDLE; edge counter, bit_counter and parity accumulator all 0.
  - All outputs 0.
  - Applies mid-frame: the frame is abandoned, no data_valid, flags cleared.
- Config capture: Prescale, PAR_EN and PAR_TYP are latched on start detection. Changes mid-frame are ignored.
- Edge counter:
  - Counts 0..P-1 per bit period, where P is the latched prescale. Wraps to 0 at P-1.
  - Held at 0 in IDLE.
- Sampling:
  - RX_IN is sampled at edge counts P/2-1, P/2 and P/2+1.
  - sampled_bit is registered as the 2-of-3 majority at edge P/2+2 and held until the next bit's update.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_IN==0 -> START, edge counter cleared, par_err and stp_err cleared.
- START, at edge P-1:
  - sampled_bit==1 -> glitch; go to IDLE with no outputs asserted.
  - Otherwise -> DATA with bit index 0.
- DATA, at edge P-1 of each bit:
  - deser_en=1 for exactly one cycle, with bit_counter = index+1 and sampled_bit stable in that same cycle.
  - Parity accumulator ^= sampled_bit.
  - After index 7: go to PARITY if PAR_EN, else STOP.
- bit_counter:
  - Updates at the start of each data bit and holds through that bit.
  - Set to 0 when leaving DATA.
- PARITY, at edge P-1:
  - Expected bit = accumulator ^ PAR_TYP.
  - Mismatch -> par_err=1, sticky until the next start detection or reset.
  - Then go to STOP.
- STOP, at edge P-1:
  - sampled_bit==0 -> stp_err=1 (sticky, same clearing rule as par_err).
  - data_valid=1 for the next cycle only, if neither par_err nor stp_err is set (including the stop result from this cycle).
  - Always go to IDLE.
- Back-to-back frames: a falling edge in the first IDLE cycle after STOP is detected with no lost cycle.
- Frame length in CLK cycles:
  - P*10 without parity.
  - P*11 with parity.

Optional Feature:
- Macro: RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer before all logic. Every RX-related event is delayed by 2 cycles; frame length is unchanged.
- Undefined: RX_IN is used directly and must already be synchronous to CLK.

Test Plan:
- Test 1 (clean frame, no parity):
  - Stimulus: Prescale=8, PAR_EN=0, byte 0xA5 LSB first.
  - Response: 8 deser_en pulses with bit_counter 1..8 and sampled_bit 1,0,1,0,0,1,0,1. data_valid pulses once, 80 cycles after the start edge. par_err=stp_err=0.
- Test 2 (parity error):
  - Stimulus: Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x03, parity bit driven 1 (wrong).
  - Response: par_err=1, no data_valid. The next good frame clears par_err and produces data_valid.
- Test 3 (start glitch):
  - Stimulus: RX_IN low for 3 cycles then high, Prescale=8.
  - Response: return to IDLE after 8 cycles; no deser_en, no data_valid, no errors.
- Test 4 (stop error):
  - Stimulus: frame 0x5A with the stop bit driven 0.
  - Response: stp_err=1 and no data_valid.
- Test 5 (majority vote):
  - Stimulus: single-cycle inversion at sample point P/2 of data bit 3, Prescale=32.
  - Response: sampled_bit for bit_counter=4 equals the undisturbed value; data_valid=1.
- Test 6 (reset mid-frame):
  - Stimulus: RST=1 for one cycle during data bit 5.
  - Response: the next cycle shows all outputs 0 with state IDLE, and no data_valid for that frame. A following frame is received correctly.
